// File: rtl/bpu_bht_pkg.sv
// Shared types and counter-constant helpers for the branch history table / BTB.
package bpu_bht_pkg;

   localparam logic [31:0] PC_STEP = 32'd4;

   // Table write selected by the resolve stage for the EX instruction.
   typedef enum logic [1:0] {
      UPD_NONE,
      UPD_STEP,
      UPD_ALLOC,
      UPD_KILL
   } upd_e;

   function automatic int unsigned ctr_wt(input int unsigned w);
      return 1 << (w - 1);
   endfunction

   function automatic int unsigned ctr_wnt(input int unsigned w);
      return (1 << (w - 1)) - 1;
   endfunction

   function automatic int unsigned ctr_max(input int unsigned w);
      return (1 << w) - 1;
   endfunction

endpackage

// File: rtl/bpu_sat_ctr.sv
// Saturating up/down counter with synchronous reset value and parallel load.
module bpu_sat_ctr #(
   parameter int unsigned W       = 2,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= RST_VAL;
      end else if (load) begin
         count <= load_val;
      end else if (inc && count != '1) begin
         count <= count + 1'b1;
      end else if (dec && count != '0) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/bpu_bht.sv
// Direct-mapped branch history table plus target buffer: fetch-stage lookup,
// EX-stage resolve (flush/redirect), table update and saturating statistics.
module bpu_bht
   import bpu_bht_pkg::*;
#(
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned CTR_W   = 2,
   parameter int unsigned TAG_W   = 8,
   parameter int unsigned STAT_W  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [31:0]       if_pc_i,
   output logic              pred_hit_o,
   output logic              pred_taken_o,
   output logic [31:0]       pred_target_o,
   input  logic              ex_valid_i,
   input  logic [31:0]       ex_pc_i,
   input  logic              ex_is_br_i,
   input  logic              ex_is_jmp_i,
   input  logic              ex_taken_i,
   input  logic [31:0]       ex_target_i,
   input  logic              ex_pred_taken_i,
   input  logic [31:0]       ex_pred_target_i,
   output logic              flush_o,
   output logic [31:0]       redirect_pc_o,
   output logic [STAT_W-1:0] br_cnt_o,
   output logic [STAT_W-1:0] mis_cnt_o
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam logic [CTR_W-1:0] WT  = CTR_W'(ctr_wt(CTR_W));
   localparam logic [CTR_W-1:0] WNT = CTR_W'(ctr_wnt(CTR_W));
   localparam logic [CTR_W-1:0] MAX = CTR_W'(ctr_max(CTR_W));

   logic              valid_q  [ENTRIES];
   logic [TAG_W-1:0]  tag_q    [ENTRIES];
   logic [31:0]       target_q [ENTRIES];
   logic [CTR_W-1:0]  ctr_q    [ENTRIES];

   logic [IDX_W-1:0]  if_idx, ex_idx;
   logic [TAG_W-1:0]  if_tag, ex_tag;
   logic              ex_hit, ex_ctl, ex_taken;
   logic [31:0]       actual_npc;
   logic              flush;
   upd_e              upd;
   logic [CTR_W-1:0]  ld_val;
   logic              unused_bits;

   assign unused_bits = ^{if_pc_i, ex_pc_i, ex_pred_taken_i};

   assign if_idx = if_pc_i[IDX_W+1:2];
   assign if_tag = if_pc_i[IDX_W+TAG_W+1:IDX_W+2];
   assign ex_idx = ex_pc_i[IDX_W+1:2];
   assign ex_tag = ex_pc_i[IDX_W+TAG_W+1:IDX_W+2];

   // Lookup reads the registered table, so a same-cycle update is not seen.
   always_comb begin
      pred_hit_o    = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
      pred_taken_o  = pred_hit_o && ctr_q[if_idx][CTR_W-1];
      pred_target_o = pred_taken_o ? target_q[if_idx] : if_pc_i + PC_STEP;
   end

   always_comb begin
      ex_ctl        = ex_is_br_i || ex_is_jmp_i;
      ex_taken      = ex_ctl && ex_taken_i;
      ex_hit        = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
      actual_npc    = ex_taken ? ex_target_i : ex_pc_i + PC_STEP;
      flush         = ex_valid_i && !rst_i && (actual_npc != ex_pred_target_i);
      flush_o       = flush;
      redirect_pc_o = flush ? actual_npc : '0;
   end

   always_comb begin
      upd    = UPD_NONE;
      ld_val = WT;
      if (ex_valid_i) begin
         if (ex_is_jmp_i) begin
            upd    = UPD_ALLOC;
            ld_val = MAX;
         end else if (ex_is_br_i) begin
            if (ex_hit)
               upd = UPD_STEP;
            else if (ex_taken_i)
               upd = UPD_ALLOC;
         end else if (ex_hit) begin
            upd = UPD_KILL;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
         end
      end else begin
         case (upd)
            UPD_ALLOC: begin
               valid_q[ex_idx]  <= 1'b1;
               tag_q[ex_idx]    <= ex_tag;
               target_q[ex_idx] <= ex_target_i;
            end
            UPD_STEP: begin
               if (ex_taken_i)
                  target_q[ex_idx] <= ex_target_i;
            end
            UPD_KILL: valid_q[ex_idx] <= 1'b0;
            default: ;
         endcase
      end
   end

   for (genvar g = 0; g < ENTRIES; g++) begin : g_ctr
      logic sel;
      assign sel = (ex_idx == IDX_W'(g));
      bpu_sat_ctr #(
         .W       (CTR_W),
         .RST_VAL (WNT)
      ) u_ctr (
         .clk      (clk_i),
         .rst      (rst_i),
         .inc      (sel && upd == UPD_STEP && ex_taken_i),
         .dec      (sel && upd == UPD_STEP && !ex_taken_i),
         .load     (sel && upd == UPD_ALLOC),
         .load_val (ld_val),
         .count    (ctr_q[g])
      );
   end

   bpu_sat_ctr #(
      .W       (STAT_W),
      .RST_VAL ('0)
   ) u_br_cnt (
      .clk      (clk_i),
      .rst      (rst_i),
      .inc      (ex_valid_i && ex_ctl),
      .dec      (1'b0),
      .load     (1'b0),
      .load_val ('0),
      .count    (br_cnt_o)
   );

   bpu_sat_ctr #(
      .W       (STAT_W),
      .RST_VAL ('0)
   ) u_mis_cnt (
      .clk      (clk_i),
      .rst      (rst_i),
      .inc      (flush),
      .dec      (1'b0),
      .load     (1'b0),
      .load_val ('0),
      .count    (mis_cnt_o)
   );

endmodule

// File: tb/tb_bpu_bht.sv
// Directed checks of lookup, resolve, table update, statistics and reset.
module tb_bpu_bht;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] if_pc;
   logic        pred_hit, pred_taken;
   logic [31:0] pred_target;
   logic        ex_valid, ex_is_br, ex_is_jmp, ex_taken, ex_pred_taken;
   logic [31:0] ex_pc, ex_target, ex_pred_target;
   logic        flush;
   logic [31:0] redirect_pc;
   logic [31:0] br_cnt, mis_cnt;

   int unsigned n_chk = 0;
   int unsigned n_bad = 0;

   always #5 clk = ~clk;

   bpu_bht #(
      .ENTRIES (64),
      .CTR_W   (2),
      .TAG_W   (8),
      .STAT_W  (32)
   ) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .if_pc_i          (if_pc),
      .pred_hit_o       (pred_hit),
      .pred_taken_o     (pred_taken),
      .pred_target_o    (pred_target),
      .ex_valid_i       (ex_valid),
      .ex_pc_i          (ex_pc),
      .ex_is_br_i       (ex_is_br),
      .ex_is_jmp_i      (ex_is_jmp),
      .ex_taken_i       (ex_taken),
      .ex_target_i      (ex_target),
      .ex_pred_taken_i  (ex_pred_taken),
      .ex_pred_target_i (ex_pred_target),
      .flush_o          (flush),
      .redirect_pc_o    (redirect_pc),
      .br_cnt_o         (br_cnt),
      .mis_cnt_o        (mis_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic ex_set(input logic v, input logic [31:0] pc, input logic br, input logic jmp,
                         input logic tk, input logic [31:0] tgt, input logic ptk,
                         input logic [31:0] ptgt);
      ex_valid       = v;
      ex_pc          = pc;
      ex_is_br       = br;
      ex_is_jmp      = jmp;
      ex_taken       = tk;
      ex_target      = tgt;
      ex_pred_taken  = ptk;
      ex_pred_target = ptgt;
   endtask

   task automatic ex_idle();
      ex_set(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                       input logic tk, input logic [31:0] tgt);
      if_pc = pc;
      #2;
      chk({tag, ".hit"}, {31'b0, pred_hit}, {31'b0, hit});
      chk({tag, ".taken"}, {31'b0, pred_taken}, {31'b0, tk});
      chk({tag, ".target"}, pred_target, tgt);
   endtask

   task automatic resolve(input string tag, input logic fl, input logic [31:0] rd);
      #2;
      chk({tag, ".flush"}, {31'b0, flush}, {31'b0, fl});
      chk({tag, ".redirect"}, redirect_pc, rd);
   endtask

   task automatic cnts(input string tag, input logic [31:0] br, input logic [31:0] mis);
      chk({tag, ".br_cnt"}, br_cnt, br);
      chk({tag, ".mis_cnt"}, mis_cnt, mis);
   endtask

   initial begin
      #20000;
      $display("FAIL watchdog: got=timeout exp=finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst   = 1'b1;
      if_pc = 32'h0;
      ex_idle();
      tick();
      tick();
      rst = 1'b0;

      // cold lookup
      look("cold", 32'h100, 1'b0, 1'b0, 32'h104);
      cnts("cold", 0, 0);

      // first taken branch allocates with weakly-taken counter
      ex_set(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h104);
      resolve("br1", 1'b1, 32'h80);
      tick();
      ex_idle();
      cnts("br1", 1, 1);
      look("br1_look", 32'h100, 1'b1, 1'b1, 32'h80);

      // two correctly-predicted taken resolves, counter saturates
      ex_set(1'b1, 32'h100, 1'b1, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
      resolve("tk2", 1'b0, 32'h0);
      tick();
      resolve("tk3", 1'b0, 32'h0);
      tick();
      cnts("tk3", 3, 1);

      // not-taken walk: 3 -> 2 (still taken) -> 1 (not taken)
      ex_set(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
      resolve("nt1", 1'b1, 32'h104);
      tick();
      ex_idle();
      look("nt1_look", 32'h100, 1'b1, 1'b1, 32'h80);
      ex_set(1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h80, 1'b1, 32'h80);
      resolve("nt2", 1'b1, 32'h104);
      tick();
      ex_idle();
      look("nt2_look", 32'h100, 1'b1, 1'b0, 32'h104);
      cnts("nt2", 5, 3);

      // alias: same index, different tag
      look("alias", 32'h200, 1'b0, 1'b0, 32'h204);

      // stale non-branch hit: flush to fall-through and invalidate
      ex_set(1'b1, 32'h100, 1'b0, 1'b0, 1'b1, 32'h80, 1'b1, 32'h80);
      resolve("stale", 1'b1, 32'h104);
      tick();
      ex_idle();
      look("stale_look", 32'h100, 1'b0, 1'b0, 32'h104);
      cnts("stale", 5, 4);

      // non-branch correctly predicted as fall-through: nothing happens
      ex_set(1'b1, 32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h304);
      resolve("plain", 1'b0, 32'h0);
      tick();
      ex_idle();
      cnts("plain", 5, 4);

      // jump with wrong predicted target; counter loaded to max
      ex_set(1'b1, 32'h140, 1'b0, 1'b1, 1'b1, 32'h90, 1'b1, 32'h80);
      resolve("jmp", 1'b1, 32'h90);
      tick();
      ex_idle();
      look("jmp_look", 32'h140, 1'b1, 1'b1, 32'h90);
      cnts("jmp", 6, 5);

      // 3 -> 2 keeps predicting taken (proves counter was at max)
      ex_set(1'b1, 32'h140, 1'b1, 1'b0, 1'b0, 32'h90, 1'b1, 32'h90);
      resolve("jnt1", 1'b1, 32'h144);
      tick();
      ex_idle();
      look("jnt1_look", 32'h140, 1'b1, 1'b1, 32'h90);

      // 2 -> 1 while looking up the same index: lookup sees pre-update entry
      ex_set(1'b1, 32'h140, 1'b1, 1'b0, 1'b0, 32'h90, 1'b1, 32'h90);
      look("same_cyc", 32'h140, 1'b1, 1'b1, 32'h90);
      resolve("jnt2", 1'b1, 32'h144);
      tick();
      ex_idle();
      look("jnt2_look", 32'h140, 1'b1, 1'b0, 32'h144);
      cnts("jnt2", 8, 7);

      // bubble with garbage EX inputs
      ex_set(1'b0, 32'h140, 1'b1, 1'b1, 1'b1, 32'hdead_bee0, 1'b1, 32'h1234);
      resolve("bubble", 1'b0, 32'h0);
      tick();
      ex_idle();
      look("bubble_look", 32'h140, 1'b1, 1'b0, 32'h144);
      cnts("bubble", 8, 7);

      // reset during a mispredicting resolve
      rst = 1'b1;
      ex_set(1'b1, 32'h100, 1'b0, 1'b1, 1'b1, 32'h80, 1'b0, 32'h104);
      resolve("rst", 1'b0, 32'h0);
      tick();
      rst = 1'b0;
      ex_idle();
      cnts("post_rst", 0, 0);
      look("post_rst_a", 32'h100, 1'b0, 1'b0, 32'h104);
      look("post_rst_b", 32'h140, 1'b0, 1'b0, 32'h144);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
